io_bcd_display_converter: RTL

Downstream of the CPU's I/O write path: captures the 32-bit word the processor writes to the output port and converts it to three BCD digits (unidade, dezena, centena) for the seven-segment decoders. Conversion is a sequential shift-add-3 (double dabble) engine with a start/ready/done handshake. The previous digits stay displayed until a new conversion completes. Values above 999 saturate to 999 and set an overflow flag.

---
 rtl/io_bcd_display_converter_if.sv | 39 +++
 rtl/io_bcd_display_converter.sv | 103 ++++++++++
 2 files changed

// File: rtl/io_bcd_display_converter_if.sv
// Handshake and display bundle between the I/O write path
// and the BCD converter engine.
interface io_bcd_display_converter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [3:0]            unidade;
  logic [3:0]            dezena;
  logic [3:0]            centena;

  modport master (
    output start,
    output dataIn,
    input  ready,
    input  busy,
    input  done,
    input  overflow,
    input  unidade,
    input  dezena,
    input  centena
  );

  modport slave (
    input  start,
    input  dataIn,
    output ready,
    output busy,
    output done,
    output overflow,
    output unidade,
    output dezena,
    output centena
  );
endinterface

// File: rtl/io_bcd_display_converter.sv
// Sequential double-dabble converter: output-port word to three
// held BCD digits, saturating at MAX_VALUE with an overflow flag.
module io_bcd_display_converter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VALUE  = 999
) (
  input logic clock,
  input logic reset,
  io_bcd_display_converter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAX_VALUE);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [11:0]           acc;
  logic [11:0]           adj;
  logic [CW-1:0]         cnt;
  logic                  satFlag;
  logic                  doneReg;
  logic                  overReg;
  logic [3:0]            uniReg;
  logic [3:0]            dezReg;
  logic [3:0]            cenReg;

  function automatic logic [3:0] addThree(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    adj = {addThree(acc[11:8]),
           addThree(acc[7:4]),
           addThree(acc[3:0])};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      acc      <= '0;
      cnt      <= '0;
      satFlag  <= 1'b0;
      doneReg  <= 1'b0;
      overReg  <= 1'b0;
      uniReg   <= '0;
      dezReg   <= '0;
      cenReg   <= '0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            shiftReg <= bus.dataIn;
            satFlag  <= (bus.dataIn > MAXV);
            acc      <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // One extra SHIFT cycle after the last shift keeps latency at W+2
          if (cnt == LAST) begin
            state <= FINISH;
          end else begin
            acc      <= 12'({adj, shiftReg[DATA_WIDTH-1]});
            shiftReg <= {shiftReg[DATA_WIDTH-2:0], 1'b0};
            cnt      <= cnt + 1'b1;
          end
        end
        FINISH: begin
          if (satFlag) begin
            cenReg <= 4'd9;
            dezReg <= 4'd9;
            uniReg <= 4'd9;
          end else begin
            cenReg <= acc[11:8];
            dezReg <= acc[7:4];
            uniReg <= acc[3:0];
          end
          overReg <= satFlag;
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;
  assign bus.overflow = overReg;
  assign bus.unidade  = uniReg;
  assign bus.dezena   = dezReg;
  assign bus.centena  = cenReg;

endmodule
